// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: mul/div sequencer state encoding and register-index width.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: branch flush, load-use bubble and multi-cycle mul/div freeze.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 ex_muldiv_start,
  output logic                 stall_pc,
  output logic                 stall_if_id,
  output logic                 flush_if_id,
  output logic                 stall_id_ex,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 muldiv_busy,
  output logic                 muldiv_done
);

  localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             in_run;
  logic             md_last;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign in_run  = (state_q == RUN);
  assign md_last = (state_q == MD_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_run) begin
      if (ex_muldiv_start && !ex_branch_taken) begin
        state_d = MD_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q == '0) begin
      state_d = RUN;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign muldiv_busy = (state_q == MD_BUSY);

  // Priority in RUN is branch > mul/div start > load-use; in MD_BUSY EX is frozen,
  // so only the counter matters and the final cycle releases the pipeline.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    muldiv_done  = 1'b0;
    if (!reset) begin
      if (in_run) begin
        if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ex_muldiv_start) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end else if (md_last) begin
        muldiv_done = 1'b1;
      end else begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with MULDIV_CYCLES=4.
module tb_hazard_control_unit;

  // Output vector bit order:
  // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem, muldiv_busy, muldiv_done}
  localparam logic [7:0] IDLE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0010_1000;
  localparam logic [7:0] MDS  = 8'b1101_0100;
  localparam logic [7:0] MDB  = 8'b1101_0110;
  localparam logic [7:0] MDD  = 8'b0000_0011;
  localparam logic [7:0] BSY  = 8'b0000_0010;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_muldiv_start;
  logic       stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem;
  logic       muldiv_busy, muldiv_done;
  logic [7:0] outs;

  int n_tests;
  int n_fail;

  hazard_control_unit #(.MULDIV_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_muldiv_start (ex_muldiv_start),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .stall_id_ex     (stall_id_ex),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done)
  );

  assign outs = {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
                 flush_id_ex, flush_ex_mem, muldiv_busy, muldiv_done};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs after the falling edge, then settle before sampling.
  task automatic step(input logic rst, input logic br, input logic st, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2);
    @(negedge clk);
    reset           = rst;
    ex_branch_taken = br;
    ex_muldiv_start = st;
    ex_mem_read     = mr;
    ex_rd           = rd;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_use_rs1      = u1;
    id_use_rs2      = u2;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", outs, IDLE);
    end
    // reset wins over a simultaneous mul/div start
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL reset_vs_start: got %b expected %b", outs, IDLE);
    end
    idle();
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL reset_after: got %b expected %b", outs, IDLE);
    end
  endtask

  task automatic test_load_use();
    // V1: rs2 dependency
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    n_tests++;
    if (outs !== LU) begin
      n_fail++; $display("FAIL v1_load_use: got %b expected %b", outs, LU);
    end
    idle();
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL v1_release: got %b expected %b", outs, IDLE);
    end
    // rs1 dependency
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 5'd17, 5'd3, 1'b1, 1'b0);
    n_tests++;
    if (outs !== LU) begin
      n_fail++; $display("FAIL lu_rs1: got %b expected %b", outs, LU);
    end
    // matching index but operand not read
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL lu_unused: got %b expected %b", outs, IDLE);
    end
    // matching index but not a load
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL lu_not_load: got %b expected %b", outs, IDLE);
    end
    // V2: x0 destination
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL v2_x0: got %b expected %b", outs, IDLE);
    end
  endtask

  task automatic test_muldiv();
    logic [7:0] seq [4];
    seq = '{MDB, MDB, MDD, IDLE};
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== MDS) begin
      n_fail++; $display("FAIL v3_start: got %b expected %b", outs, MDS);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_tests++;
      if (outs !== seq[i]) begin
        n_fail++; $display("FAIL v3_cycle%0d: got %b expected %b", i + 2, outs, seq[i]);
      end
    end
  endtask

  task automatic test_branch();
    // V4: branch beats load-use
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    n_tests++;
    if (outs !== BR) begin
      n_fail++; $display("FAIL v4_branch_lu: got %b expected %b", outs, BR);
    end
    // branch cancels a mul/div start: no busy afterwards
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== BR) begin
      n_fail++; $display("FAIL branch_start: got %b expected %b", outs, BR);
    end
    idle();
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL branch_start_after: got %b expected %b", outs, IDLE);
    end
  endtask

  task automatic test_muldiv_lu();
    logic [7:0] seq [3];
    seq = '{MDB, MDB, MDD};
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
    n_tests++;
    if (outs !== MDS) begin
      n_fail++; $display("FAIL md_lu_start: got %b expected %b", outs, MDS);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_tests++;
      if (outs !== seq[i]) begin
        n_fail++; $display("FAIL md_lu_cycle%0d: got %b expected %b", i + 2, outs, seq[i]);
      end
    end
  endtask

  task automatic test_reset_busy();
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle();
    n_tests++;
    if (outs !== MDB) begin
      n_fail++; $display("FAIL v5_busy1: got %b expected %b", outs, MDB);
    end
    // V5: reset on the second busy cycle; busy stays visible until the edge
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== BSY) begin
      n_fail++; $display("FAIL v5_reset_cycle: got %b expected %b", outs, BSY);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_tests++;
      if (outs !== IDLE) begin
        n_fail++; $display("FAIL v5_after%0d: got %b expected %b", i, outs, IDLE);
      end
    end
  endtask

  task automatic test_busy_ignores();
    logic [7:0] seq [3];
    seq = '{MDB, MDB, MDD};
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    // V6: branch, start and load-use all ignored while busy
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== seq[0]) begin
      n_fail++; $display("FAIL v6_branch: got %b expected %b", outs, seq[0]);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    n_tests++;
    if (outs !== seq[1]) begin
      n_fail++; $display("FAIL v6_start_lu: got %b expected %b", outs, seq[1]);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== seq[2]) begin
      n_fail++; $display("FAIL v6_done: got %b expected %b", outs, seq[2]);
    end
  endtask

  task automatic test_back_to_back();
    // load-use immediately after the done cycle is honoured in RUN
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 5'd0, 5'd12, 1'b0, 1'b1);
    n_tests++;
    if (outs !== LU) begin
      n_fail++; $display("FAIL b2b_lu: got %b expected %b", outs, LU);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (outs !== MDS) begin
      n_fail++; $display("FAIL b2b_start: got %b expected %b", outs, MDS);
    end
    idle();
    idle();
    idle();
    n_tests++;
    if (outs !== MDD) begin
      n_fail++; $display("FAIL b2b_done: got %b expected %b", outs, MDD);
    end
    idle();
    n_tests++;
    if (outs !== IDLE) begin
      n_fail++; $display("FAIL b2b_run: got %b expected %b", outs, IDLE);
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    ex_branch_taken = 1'b0;
    ex_muldiv_start = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rd           = 5'd0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_use_rs1      = 1'b0;
    id_use_rs2      = 1'b0;

    test_reset();
    test_load_use();
    test_muldiv();
    test_branch();
    test_muldiv_lu();
    test_reset_busy();
    test_busy_ignores();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have parameter MULDIV_CYCLES, default 4: total EX-stage occupancy in cycles of a mul/div instruction (legal range 2..16).
REQ-002 The block SHALL have ports exactly as follows:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_muldiv_start  in  1  a mul/div instruction entered EX this cycle.
- stall_pc  out  1  PC holds its value.
- stall_if_id  out  1  IF/ID register holds (drives its stall input).
- flush_if_id  out  1  IF/ID register clears (drives its flush input).
- stall_id_ex  out  1  ID/EX register holds.
- flush_id_ex  out  1  ID/EX register loads a bubble.
- flush_ex_mem  out  1  EX/MEM register loads a bubble.
- muldiv_busy  out  1  FSM is in MD_BUSY.
- muldiv_done  out  1  one-cycle pulse on the final mul/div cycle.

Function
REQ-003 FSM states SHALL be RUN and MD_BUSY, with a down-counter cnt of width clog2(MULDIV_CYCLES).
- REQ-004 RUN -> MD_BUSY SHALL occur when ex_muldiv_start=1 and ex_branch_taken=0; cnt loads MULDIV_CYCLES-2.
- REQ-005 In MD_BUSY, cnt SHALL decrement each cycle; at cnt=0 muldiv_done=1 for that cycle and the next state is RUN.
- REQ-006 muldiv_busy SHALL equal (state==MD_BUSY) and SHALL be registered; muldiv_done SHALL be combinational from state and cnt.
- REQ-007 In the cycle ex_muldiv_start=1 and in every MD_BUSY cycle except the final one (cnt!=0): stall_pc=stall_if_id=stall_id_ex=1 and flush_ex_mem=1.
- REQ-008 On the final MD_BUSY cycle all stall and flush outputs SHALL be 0, so the result advances to MEM on the next edge.
- REQ-009 Load-use hazard SHALL be defined as ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- REQ-010 A load-use hazard in RUN SHALL give stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly that cycle, with no state change (1-cycle bubble).
- REQ-011 ex_branch_taken=1 in RUN SHALL give flush_if_id=1 and flush_id_ex=1, with all stall outputs 0 (2 wrong-path instructions killed).
- REQ-012 Priority SHALL be: branch > muldiv start > load-use.
  - Branch together with load-use: flush only.
  - Branch together with muldiv_start: the start is ignored.
  - Muldiv start together with load-use: the REQ-007 outputs apply.
- REQ-013 In MD_BUSY, ex_branch_taken, ex_muldiv_start and load-use SHALL be ignored, because EX is frozen on the mul/div instruction.
- REQ-014 Outputs that are not asserted by any rule SHALL be 0. A stall and a flush of the same register SHALL never be asserted together.

Reset
REQ-015 While reset=1, state SHALL be RUN and cnt=0 on the next edge. All outputs SHALL be 0 while state is RUN with inputs idle.
REQ-016 Reset asserted during MD_BUSY SHALL abort the operation: no muldiv_done pulse, and muldiv_busy=0 after the edge.
REQ-017 Reset SHALL override all inputs in the same cycle.

Structure
REQ-018 The state encoding (RUN=0, MD_BUSY=1) and the register-index width (5) SHALL live in the shared package pipeline_pkg. MULDIV_CYCLES SHALL remain a module parameter.
REQ-019 Load-use detection SHALL be a combinational sub-module, load_use_detect. The FSM and the output mux SHALL be in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- V1 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle, then 0.
- V2 x0 case: as V1 but ex_rd=0 -> all outputs 0.
- V3 Mul/div: ex_muldiv_start=1 for 1 cycle with MULDIV_CYCLES=4 -> stalls and flush_ex_mem high for 3 cycles; muldiv_busy high for cycles 2-4; muldiv_done on cycle 4; RUN on cycle 5.
- V4 Branch plus load-use in the same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0.
- V5 Reset on the 2nd MD_BUSY cycle -> no muldiv_done pulse, muldiv_busy=0 next cycle, all outputs 0.
- V6 Branch during MD_BUSY -> ignored; the done pulse timing is unchanged.
